load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory stage for the RV32I core, sitting directly downstream of the ALU. It takes the ALU result as the effective address and rs2 as store data. It drives a request/grant/response data-memory bus with byte enables and aligns load data with sign or zero extension. It also stalls the core (PC and regfile write) until the access completes.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles spent in REQ+RESP before the access is aborted with an error (must be >= 2).

Ports:
clk  in  1  system clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
lsu_valid  in  1  core has a load/store this instruction; held high until lsu_done
lsu_we  in  1  1 = store, 0 = load
lsu_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
lsu_addr  in  32  effective byte address (ALU result)
lsu_wdata  in  32  store data (rs2)
lsu_busy  out  1  stall request to the core
lsu_done  out  1  one-cycle completion pulse
lsu_rdata  out  32  extended load data, valid while lsu_done=1
lsu_err  out  1  pulses with lsu_done on misalignment, illegal funct3 or timeout
mem_req  out  1  bus request
mem_we  out  1  bus write
mem_be  out  4  byte enables
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  bus accepted the request this cycle
mem_rvalid  in  1  response/acknowledge; also acknowledges stores
mem_rdata  in  32  read data, valid with mem_rvalid

Behaviour:
- Reset (sync, active-high):
  - State goes to IDLE.
  - All outputs are 0, including lsu_rdata and the bus outputs.
  - The timeout counter is cleared.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - When lsu_valid=1, check the request.
  - Misaligned cases: H with addr[0]=1, or W with addr[1:0]!=0.
  - Illegal cases: funct3 outside the five listed codes. For stores, only 000, 001 and 010 are legal.
  - Misaligned or illegal: go to DONE with the error flag set. No bus activity.
  - Otherwise: latch we, funct3, addr[1:0], mem_addr, mem_be and mem_wdata, clear the counter, and go to REQ.
- REQ:
  - Hold mem_req=1 with all bus outputs stable.
  - On mem_gnt=1, go to RESP and drop mem_req on the next cycle.
- RESP:
  - Wait for mem_rvalid=1.
  - On a load, capture the extended data, then go to DONE.
  - mem_rvalid arrives at least one cycle after mem_gnt. An mem_rvalid seen in REQ or IDLE is ignored.
- DONE:
  - lsu_done=1 for exactly one cycle, then return to IDLE.
  - The core advances on this edge, so lsu_valid in the next IDLE cycle belongs to the next instruction.
- lsu_busy (combinational) = (IDLE & lsu_valid) | REQ | RESP. It is 0 in DONE.
- Latency with zero-wait grant and a next-cycle mem_rvalid: lsu_done is asserted 3 cycles after the first IDLE cycle with lsu_valid.
- Error path: lsu_done is asserted the cycle after acceptance.
- Byte lanes, with off = addr[1:0]:
  - B: be = 4'b0001 << off, wdata = {4{wdata[7:0]}}.
  - H: be = 4'b0011 << off, wdata = {2{wdata[15:0]}}.
  - W: be = 4'b1111, wdata = wdata.
  - Loads drive the same be with mem_we=0.
- Load extraction: shift mem_rdata right by 8*off, then:
  - B: sign-extend bit 7.
  - BU: zero-extend bits 7:0.
  - H: sign-extend bit 15.
  - HU: zero-extend bits 15:0.
  - W: pass through.
- lsu_rdata holds its value between accesses. It is forced to 0 on any error and on stores.
- Timeout:
  - The counter increments on every cycle spent in REQ or RESP.
  - If it reaches TIMEOUT_CYCLES-1 with no completing event (mem_gnt in REQ, mem_rvalid in RESP), go to DONE with lsu_err=1 and drop mem_req.
  - A completing event in that same final cycle wins; no error is raised.
- Reset mid-operation: on the next cycle, mem_req=0, lsu_busy=0 and the state is IDLE. A later stale mem_rvalid is ignored.

Test Plan:
- SW, addr 0x100, wdata 0xDEADBEEF, gnt in first REQ cycle, rvalid next cycle -> mem_addr=0x100, be=1111, mem_we=1; lsu_done 3 cycles after valid; err=0; rdata=0.
- LB addr 0x103 with mem_rdata 0x80123456 -> be=1000, lsu_rdata=0xFFFFFF80; LBU at the same address -> 0x00000080.
- LH addr 0x102 with mem_rdata 0x8001ABCD -> be=1100, lsu_rdata=0xFFFF8001. SH addr 0x102 with wdata 0x00001234 -> be=1100, mem_wdata=0x12341234.
- LW addr 0x101 -> lsu_done and lsu_err one cycle after valid; mem_req never asserted; lsu_rdata=0.
- gnt held low for 3 cycles -> mem_req stays 1 with addr/be/wdata stable, then proceeds. With TIMEOUT_CYCLES=16 and no rvalid ever -> lsu_err=1, lsu_done after 16 cycles in REQ+RESP, mem_req=0.
- Reset asserted in RESP -> next cycle state IDLE, busy=0, mem_req=0; a subsequent rvalid produces no lsu_done.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: checks and aligns a core memory access, runs it over a
// request/grant/response bus and stalls the core until the access completes.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_valid,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_cnt_last;
    logic [2:0]        r_funct3;
    logic [2:0]        w_funct3_nxt;
    logic [1:0]        r_off;
    logic [1:0]        w_off_nxt;
    logic              w_we_nxt;
    logic [31:0]       w_addr_nxt;
    logic [3:0]        w_be_nxt;
    logic [31:0]       w_wdata_nxt;
    logic [31:0]       w_rdata_nxt;
    logic              w_err_nxt;

    logic              w_illegal;
    logic              w_misalign;
    logic [3:0]        w_req_be;
    logic [31:0]       w_req_wdata;
    logic [31:0]       w_shifted;
    logic [31:0]       w_load_data;

    assign lsu_busy   = ((r_state == S_IDLE) && lsu_valid) || (r_state == S_REQ) || (r_state == S_RESP);
    assign w_cnt_last = (r_cnt == CNT_LAST);
    // Saturates so a grant in the last budget cycle cannot wrap into a fresh budget
    assign w_cnt_inc  = w_cnt_last ? r_cnt : r_cnt + CNT_W'(1);

    // Request check and byte-lane steering for the incoming access
    always_comb begin
        w_illegal = 1'b0;
        if (lsu_we) begin
            w_illegal = lsu_funct3[2] || (lsu_funct3[1:0] == 2'b11);
        end else begin
            w_illegal = (lsu_funct3 == 3'b011) || (lsu_funct3 == 3'b110) || (lsu_funct3 == 3'b111);
        end
        w_misalign = ((lsu_funct3[1:0] == 2'b01) && lsu_addr[0])
                  || ((lsu_funct3[1:0] == 2'b10) && (lsu_addr[1:0] != 2'b00));
        case (lsu_funct3[1:0])
            2'b00: begin
                w_req_be    = 4'(4'b0001 << lsu_addr[1:0]);
                w_req_wdata = {4{lsu_wdata[7:0]}};
            end
            2'b01: begin
                w_req_be    = 4'(4'b0011 << lsu_addr[1:0]);
                w_req_wdata = {2{lsu_wdata[15:0]}};
            end
            default: begin
                w_req_be    = 4'b1111;
                w_req_wdata = lsu_wdata;
            end
        endcase
    end

    // Load data alignment and extension
    always_comb begin
        w_shifted = mem_rdata >> {r_off, 3'b000};
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load_data = {24'h000000, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_load_data = {16'h0000, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_we_nxt     = mem_we;
        w_funct3_nxt = r_funct3;
        w_off_nxt    = r_off;
        w_addr_nxt   = mem_addr;
        w_be_nxt     = mem_be;
        w_wdata_nxt  = mem_wdata;
        w_rdata_nxt  = lsu_rdata;
        w_err_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (lsu_valid) begin
                    if (w_illegal || w_misalign) begin
                        w_state_nxt = S_DONE;
                        w_err_nxt   = 1'b1;
                        w_rdata_nxt = '0;
                    end else begin
                        w_state_nxt  = S_REQ;
                        w_cnt_nxt    = '0;
                        w_we_nxt     = lsu_we;
                        w_funct3_nxt = lsu_funct3;
                        w_off_nxt    = lsu_addr[1:0];
                        w_addr_nxt   = {lsu_addr[31:2], 2'b00};
                        w_be_nxt     = w_req_be;
                        w_wdata_nxt  = w_req_wdata;
                    end
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    w_state_nxt = S_RESP;
                    w_cnt_nxt   = w_cnt_inc;
                end else if (w_cnt_last) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_RESP: begin
                if (mem_rvalid) begin
                    w_state_nxt = S_DONE;
                    w_rdata_nxt = mem_we ? 32'h0 : w_load_data;
                end else if (w_cnt_last) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_funct3  <= '0;
            r_off     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lsu_done  <= 1'b0;
            lsu_err   <= 1'b0;
            lsu_rdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_funct3  <= w_funct3_nxt;
            r_off     <= w_off_nxt;
            mem_req   <= (w_state_nxt == S_REQ);
            mem_we    <= w_we_nxt;
            mem_be    <= w_be_nxt;
            mem_addr  <= w_addr_nxt;
            mem_wdata <= w_wdata_nxt;
            lsu_done  <= (w_state_nxt == S_DONE);
            lsu_err   <= w_err_nxt;
            lsu_rdata <= w_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of accesses against a bus responder, with
// expected results queued at issue and checked at lsu_done, plus reset sequences.
module tb_load_store_unit;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_valid;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_busy;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .lsu_valid  (lsu_valid),
        .lsu_we     (lsu_we),
        .lsu_funct3 (lsu_funct3),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_busy   (lsu_busy),
        .lsu_done   (lsu_done),
        .lsu_rdata  (lsu_rdata),
        .lsu_err    (lsu_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_wait;
        bit          rv;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input int gnt_wait,
                                input bit rv, input logic [3:0] be, input logic [31:0] mwdata,
                                input logic [31:0] exp_rd, input logic exp_err, input int lat);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.gnt_wait = gnt_wait; v.rv = rv; v.be = be; v.mwdata = mwdata;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.lat = lat;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; lsu_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one access, act as the bus slave, and score it when lsu_done appears
    task automatic run_vec(input int idx, input vec_t v);
        exp_t        e;
        int          req_n;
        bit          granted, seen_req, done, busy_ok, stable;
        logic [31:0] a0, w0;
        logic [3:0]  b0;
        logic        we0;
        e.rd = v.exp_rd; e.err = v.exp_err; e.lat = v.lat;
        sb.push_back(e);
        @(negedge clk);
        lsu_valid = 1'b1; lsu_we = v.we; lsu_funct3 = v.f3; lsu_addr = v.addr; lsu_wdata = v.wdata;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        req_n = 0; granted = 0; seen_req = 0; done = 0; busy_ok = 1; stable = 1;
        a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0;
        #1;
        if (!lsu_busy) busy_ok = 0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (lsu_done) begin
                e = sb.pop_front();
                check($sformatf("v%0d latency", idx), 32'(k), 32'(e.lat));
                check($sformatf("v%0d rdata", idx), lsu_rdata, e.rd);
                check($sformatf("v%0d err", idx), 32'(lsu_err), 32'(e.err));
                check($sformatf("v%0d busy_in_done", idx), 32'(lsu_busy), 32'h0);
                check($sformatf("v%0d req_at_done", idx), 32'(mem_req), 32'h0);
                check($sformatf("v%0d busy_during", idx), 32'(busy_ok), 32'h1);
                if (v.lat == 1) check($sformatf("v%0d no_bus", idx), 32'(seen_req), 32'h0);
                if (seen_req) check($sformatf("v%0d bus_stable", idx), 32'(stable), 32'h1);
                done = 1;
            end else begin
                if (!lsu_busy) busy_ok = 0;
                if (mem_req) begin
                    if (!seen_req) begin
                        check($sformatf("v%0d mem_addr", idx), mem_addr, v.addr & ~32'h3);
                        check($sformatf("v%0d mem_be", idx), 32'(mem_be), 32'(v.be));
                        check($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.we));
                        check($sformatf("v%0d mem_wdata", idx), mem_wdata, v.mwdata);
                        a0 = mem_addr; w0 = mem_wdata; b0 = mem_be; we0 = mem_we;
                    end else if (mem_addr !== a0 || mem_wdata !== w0 || mem_be !== b0 || mem_we !== we0) begin
                        stable = 0;
                    end
                    seen_req = 1;
                    if (req_n == v.gnt_wait) begin
                        mem_gnt = 1'b1;
                        granted = 1;
                    end
                    req_n++;
                end else if (granted && v.rv) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = v.rdata;
                end
            end
        end
        lsu_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL v%0d no_done: lsu_done never seen within 40 cycles, required by cycle %0d", idx, v.lat);
            e = sb.pop_front();
            do_reset();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'b000;
        lsu_addr = '0; lsu_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        //        we    f3      addr          wdata         rdata       gw  rv  be       mwdata        exp_rd        err  lat
        vecs.push_back(mk(1'b1, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 32'h55555555, 0, 1, 4'b1111, 32'hDEADBEEF, 32'h00000000, 1'b0, 3));
        vecs.push_back(mk(1'b0, 3'b000, 32'h0000_0103, 32'h000000A5, 32'h80123456, 0, 1, 4'b1000, 32'hA5A5A5A5, 32'hFFFFFF80, 1'b0, 3));
        vecs.push_back(mk(1'b0, 3'b100, 32'h0000_0103, 32'h000000A5, 32'h80123456, 0, 1, 4'b1000, 32'hA5A5A5A5, 32'h00000080, 1'b0, 3));
        vecs.push_back(mk(1'b0, 3'b001, 32'h0000_0102, 32'h00000000, 32'h8001ABCD, 0, 1, 4'b1100, 32'h00000000, 32'hFFFF8001, 1'b0, 3));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0101, 32'h00000000, 32'h11111111, 0, 1, 4'b1111, 32'h00000000, 32'h00000000, 1'b1, 1));
        vecs.push_back(mk(1'b1, 3'b001, 32'h0000_0102, 32'h00001234, 32'h00000000, 0, 1, 4'b1100, 32'h12341234, 32'h00000000, 1'b0, 3));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0204, 32'h00000000, 32'h12345678, 3, 1, 4'b1111, 32'h00000000, 32'h12345678, 1'b0, 6));
        vecs.push_back(mk(1'b0, 3'b101, 32'h0000_0102, 32'h00000000, 32'h8001ABCD, 0, 1, 4'b1100, 32'h00000000, 32'h00008001, 1'b0, 3));
        vecs.push_back(mk(1'b0, 3'b000, 32'h0000_0101, 32'h00000000, 32'h0000F100, 1, 1, 4'b0010, 32'h00000000, 32'hFFFFFFF1, 1'b0, 4));
        vecs.push_back(mk(1'b0, 3'b011, 32'h0000_0100, 32'h00000000, 32'h00000000, 0, 1, 4'b1111, 32'h00000000, 32'h00000000, 1'b1, 1));
        vecs.push_back(mk(1'b1, 3'b000, 32'h0000_0102, 32'h000000C3, 32'h00000000, 0, 1, 4'b0100, 32'hC3C3C3C3, 32'h00000000, 1'b0, 3));
        vecs.push_back(mk(1'b1, 3'b100, 32'h0000_0100, 32'h000000C3, 32'h00000000, 0, 1, 4'b0001, 32'h00000000, 32'h00000000, 1'b1, 1));
        vecs.push_back(mk(1'b0, 3'b001, 32'h0000_0103, 32'h00000000, 32'h00000000, 0, 1, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 1));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0300, 32'h00000000, 32'h00000000, 0, 0, 4'b1111, 32'h00000000, 32'h00000000, 1'b1, 17));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0304, 32'h00000000, 32'h00000000, 99, 1, 4'b1111, 32'h00000000, 32'h00000000, 1'b1, 17));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0308, 32'h00000000, 32'hCAFEF00D, 14, 1, 4'b1111, 32'h00000000, 32'hCAFEF00D, 1'b0, 17));
        vecs.push_back(mk(1'b0, 3'b101, 32'h0000_0100, 32'h00000000, 32'h1234FFFE, 0, 1, 4'b0011, 32'h00000000, 32'h0000FFFE, 1'b0, 3));

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst lsu_done", 32'(lsu_done), 32'h0);
        check("rst lsu_err", 32'(lsu_err), 32'h0);
        check("rst lsu_rdata", lsu_rdata, 32'h0);
        check("rst lsu_busy", 32'(lsu_busy), 32'h0);
        check("rst mem_req", 32'(mem_req), 32'h0);
        check("rst mem_we", 32'(mem_we), 32'h0);
        check("rst mem_be", 32'(mem_be), 32'h0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Idle hold: stray responses do not complete anything or disturb lsu_rdata
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hBAD0BAD0;
            check($sformatf("idle%0d done", i), 32'(lsu_done), 32'h0);
            check($sformatf("idle%0d rdata_hold", i), lsu_rdata, 32'h0000FFFE);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("idle rdata_hold_end", lsu_rdata, 32'h0000FFFE);

        // Reset while waiting for the response
        lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h0000_0400;
        @(negedge clk);
        check("midrst req_up", 32'(mem_req), 32'h1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("midrst in_resp_busy", 32'(lsu_busy), 32'h1);
        reset = 1'b1;
        lsu_valid = 1'b0;
        @(negedge clk);
        check("midrst mem_req", 32'(mem_req), 32'h0);
        check("midrst busy", 32'(lsu_busy), 32'h0);
        check("midrst done", 32'(lsu_done), 32'h0);
        reset = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h87654321;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("stale done1", 32'(lsu_done), 32'h0);
        @(negedge clk);
        check("stale done2", 32'(lsu_done), 32'h0);
        check("stale rdata", lsu_rdata, 32'h0);

        run_vec(100, mk(1'b0, 3'b000, 32'h0000_0500, 32'h0, 32'h0000007F, 0, 1, 4'b0001, 32'h0, 32'h0000007F, 1'b0, 3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
